// File: rtl/skid_buffer.sv
// Valid/ready register slice with a one-word skid register.
// in_rdy and out_vld decode the state flop only, so out_rdy has no combinational path to in_rdy.
module skid_buffer #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         arst,
    input  logic         in_vld,
    input  logic [W-1:0] in_dat,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_dat,
    input  logic         out_rdy,
    output logic [1:0]   occ
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StFull  = 2'd1,
        StSkid  = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            StEmpty: begin
                if (in_vld) begin
                    main_d  = in_dat;
                    state_d = StFull;
                end
            end
            StFull: begin
                if (in_vld && out_rdy) begin
                    main_d = in_dat;
                end else if (in_vld) begin
                    // Consumer stalled: park the newly accepted word behind main.
                    skid_d  = in_dat;
                    state_d = StSkid;
                end else if (out_rdy) begin
                    state_d = StEmpty;
                end
            end
            StSkid: begin
                if (out_rdy) begin
                    main_d  = skid_q;
                    state_d = StFull;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q <= StEmpty;
        end else begin
            state_q <= state_d;
        end
    end

    // Payload registers carry no reset; validity lives entirely in state_q.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    assign out_vld = (state_q != StEmpty);
    assign in_rdy  = (state_q != StSkid);
    assign out_dat = main_q;
    assign occ     = (state_q == StSkid) ? 2'd2 : ((state_q == StFull) ? 2'd1 : 2'd0);

    occ_in_range: assert property (@(posedge clk) disable iff (arst) occ != 2'd3);

    no_accept_in_skid: assert property (@(posedge clk) disable iff (arst)
        !(state_q == StSkid && in_vld && in_rdy));

    out_stable_on_stall: assert property (@(posedge clk) disable iff (arst)
        (out_vld && !out_rdy) |=> (out_vld && $stable(out_dat)));

endmodule

// File: tb/tb_skid_buffer.sv
// Directed and random-backpressure bench for skid_buffer.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_skid_buffer;

    localparam int unsigned W = 32;

    logic         clk;
    logic         arst;
    logic         in_vld;
    logic [W-1:0] in_dat;
    logic         in_rdy;
    logic         out_vld;
    logic [W-1:0] out_dat;
    logic         out_rdy;
    logic [1:0]   occ;

    int n_checks = 0;
    int n_fail   = 0;

    skid_buffer #(.W(W)) dut (
        .clk     (clk),
        .arst    (arst),
        .in_vld  (in_vld),
        .in_dat  (in_dat),
        .in_rdy  (in_rdy),
        .out_vld (out_vld),
        .out_dat (out_dat),
        .out_rdy (out_rdy),
        .occ     (occ)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks control outputs; data only when a word is expected to be present.
    task automatic expect_state(input string tag, input logic [1:0] e_occ, input logic [W-1:0] e_dat);
        check({tag, ".occ"}, W'(occ), W'(e_occ));
        check({tag, ".out_vld"}, W'(out_vld), W'(e_occ != 2'd0));
        check({tag, ".in_rdy"}, W'(in_rdy), W'(e_occ != 2'd2));
        if (e_occ != 2'd0) check({tag, ".out_dat"}, out_dat, e_dat);
    endtask

    logic [W-1:0] model_q[$];

    initial begin
        arst    = 1'b1;
        in_vld  = 1'b0;
        in_dat  = '0;
        out_rdy = 1'b0;

        // Reset then idle
        tick();
        tick();
        expect_state("reset", 2'd0, '0);
        arst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            expect_state("idle", 2'd0, '0);
        end

        // Streaming at one word per cycle
        out_rdy = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_vld = 1'b1;
            in_dat = W'(i);
            tick();
            expect_state("stream", 2'd1, W'(i));
        end
        in_vld = 1'b0;
        tick();
        expect_state("stream_end", 2'd0, '0);

        // Stall fill then release
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_dat  = 32'hA;
        tick();
        expect_state("fill_a", 2'd1, 32'hA);
        in_dat = 32'hB;
        tick();
        expect_state("fill_b", 2'd2, 32'hA);
        in_dat = 32'hC;
        tick();
        expect_state("fill_c_held1", 2'd2, 32'hA);
        tick();
        expect_state("fill_c_held2", 2'd2, 32'hA);
        out_rdy = 1'b1;
        tick();
        expect_state("release_b", 2'd1, 32'hB);
        tick();
        expect_state("release_c", 2'd1, 32'hC);
        in_vld = 1'b0;
        tick();
        expect_state("release_end", 2'd0, '0);

        // Drain two words back to back
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        in_dat  = 32'h55;
        tick();
        expect_state("drain_load55", 2'd1, 32'h55);
        in_dat = 32'h66;
        tick();
        expect_state("drain_load66", 2'd2, 32'h55);
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        tick();
        expect_state("drain_66", 2'd1, 32'h66);
        tick();
        expect_state("drain_empty", 2'd0, '0);

        // Random backpressure against a depth-2 FIFO reference
        for (int i = 0; i < 2000; i++) begin
            logic do_in;
            logic do_out;
            expect_state("rand", 2'(model_q.size()),
                         (model_q.size() > 0) ? model_q[0] : '0);
            in_vld  = 1'($urandom_range(0, 1));
            out_rdy = 1'($urandom_range(0, 1));
            in_dat  = W'($urandom);
            do_in   = in_vld && (model_q.size() < 2);
            do_out  = out_rdy && (model_q.size() > 0);
            if (do_out) void'(model_q.pop_front());
            if (do_in) model_q.push_back(in_dat);
            tick();
        end
        expect_state("rand_final", 2'(model_q.size()),
                     (model_q.size() > 0) ? model_q[0] : '0);

        // Reset mid-operation from occ=2
        out_rdy = 1'b0;
        in_vld  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            in_dat = W'(32'h100 + i);
            tick();
        end
        check("pre_reset.occ", W'(occ), W'(2'd2));
        in_vld = 1'b0;
        #3;
        arst = 1'b1;
        #1;
        expect_state("async_reset", 2'd0, '0);
        tick();
        arst = 1'b0;
        expect_state("post_reset", 2'd0, '0);
        in_vld  = 1'b1;
        out_rdy = 1'b1;
        in_dat  = 32'h77;
        tick();
        expect_state("after_reset_77", 2'd1, 32'h77);
        in_vld = 1'b0;
        tick();
        expect_state("after_reset_alone", 2'd0, '0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
